// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready holding register toward the CPU-side bus glue.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit checked before the stop bit).
module uart_rx #(
    parameter int CLK_HZ = 1036800,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_meta;
    logic          rxs;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    logic tick;
    assign tick = (cnt == '0);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A delivery later in this block overrides this clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= CW'(HALF - 1);
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxs) begin
                            state <= DATA;
                            cnt   <= CW'(DIV - 1);
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= CW'(DIV - 1);
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bit <= rxs;
                        cnt     <= CW'(DIV - 1);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (^{shreg, par_bit}) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
`endif
                        else begin
                            state <= IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                BRK: begin
                    // Stay here until the line idles so a held-low break cannot look like a start bit.
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
